// File: rtl/closest_hit.sv
`default_nettype none
// ============================================================================
// Module   : closest_hit
// Brief    : Tracks the nearest qualified triangle hit per ray and emits one
//            resolved result per ray. Optional CLOSEST_HIT_CNT_EN adds out_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module closest_hit #(
    parameter int                 IDX_W = 16,
    parameter logic signed [31:0] T_MIN = 32'sd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_hit,
    input  logic [31:0]      in_t,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [31:0]      out_t,
    output logic [IDX_W-1:0] out_idx
`ifdef CLOSEST_HIT_CNT_EN
    ,
    output logic [IDX_W:0]   out_cnt
`endif
);

    localparam logic [0:0]  c_ST_ACCUM = 1'b0;
    localparam logic [0:0]  c_ST_DONE  = 1'b1;
    localparam logic [31:0] c_T_NONE   = 32'h7FFF_FFFF;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_best_vld;
    logic [31:0]      r_best_t;
    logic [IDX_W-1:0] r_best_idx;

    logic             w_acc;
    logic             w_out_hs;
    logic             w_qual;
    logic             w_take;
    logic             w_nxt_vld;
    logic [31:0]      w_nxt_t;
    logic [IDX_W-1:0] w_nxt_idx;

    assign in_ready  = !rst && (r_state == c_ST_ACCUM);
    assign out_valid = (r_state == c_ST_DONE);
    assign w_acc     = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;

    // Strict less-than keeps the earlier triangle on equal distance.
    assign w_qual    = in_hit && ($signed(in_t) > T_MIN);
    assign w_take    = w_qual && (!r_best_vld || ($signed(in_t) < $signed(r_best_t)));
    assign w_nxt_vld = r_best_vld || w_qual;
    assign w_nxt_t   = w_take ? in_t   : r_best_t;
    assign w_nxt_idx = w_take ? in_idx : r_best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ACCUM: if (w_acc && in_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (out_ready)        w_state_nxt = c_ST_ACCUM;
            default:                          w_state_nxt = c_ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_out_hs) begin
            r_best_vld <= 1'b0;
            r_best_t   <= c_T_NONE;
            r_best_idx <= '0;
        end else if (w_acc) begin
            r_best_vld <= w_nxt_vld;
            r_best_t   <= w_nxt_t;
            r_best_idx <= w_nxt_idx;
        end
    end

    // Result registers hold their values after the handshake until the next ray ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_hit <= 1'b0;
            out_t   <= c_T_NONE;
            out_idx <= '0;
        end else if (w_acc && in_last) begin
            out_hit <= w_nxt_vld;
            out_t   <= w_nxt_t;
            out_idx <= w_nxt_idx;
        end
    end

`ifdef CLOSEST_HIT_CNT_EN
    logic [IDX_W:0] r_cnt;
    logic [IDX_W:0] w_cnt_nxt;

    assign w_cnt_nxt = (w_qual && (r_cnt != '1)) ? (r_cnt + {{IDX_W{1'b0}}, 1'b1}) : r_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_out_hs) begin
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_out_hs) begin
            out_cnt <= '0;
        end else if (w_acc && in_last) begin
            out_cnt <= w_cnt_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
